// File: rtl/mdu_ctrl_pkg.sv
// Shared MDU definitions: md_op encodings, default latencies and op-class helpers.
// Optional madd/msub family enabled by defining MDU_MADD_EN.
package mdu_ctrl_pkg;

  typedef enum logic [3:0] {
    MD_MULT  = 4'd0,
    MD_MULTU = 4'd1,
    MD_DIV   = 4'd2,
    MD_DIVU  = 4'd3,
    MD_MTHI  = 4'd4,
    MD_MTLO  = 4'd5,
    MD_MADD  = 4'd6,
    MD_MADDU = 4'd7,
    MD_MSUB  = 4'd8,
    MD_MSUBU = 4'd9
  } md_op_e;

  typedef enum logic {
    S_IDLE,
    S_RUN
  } mdu_state_e;

  localparam int DEF_MULT_CYCLES = 5;
  localparam int DEF_DIV_CYCLES  = 10;

  function automatic logic is_mult_op(input logic [3:0] op);
    logic r;
    r = (op == MD_MULT) || (op == MD_MULTU);
`ifdef MDU_MADD_EN
    r = r || (op == MD_MADD) || (op == MD_MADDU) || (op == MD_MSUB) || (op == MD_MSUBU);
`endif
    return r;
  endfunction

  function automatic logic is_div_op(input logic [3:0] op);
    return (op == MD_DIV) || (op == MD_DIVU);
  endfunction

endpackage

// File: rtl/mdu_ctrl_if.sv
// E-stage <-> MDU signal bundle; master is the pipeline side, slave is the MDU.
interface mdu_ctrl_if;
  logic        start;
  logic [3:0]  md_op;
  logic [31:0] a;
  logic [31:0] b;
  logic        cancel;
  logic        md_in_d;
  logic        busy;
  logic        done;
  logic        stall_md;
  logic [31:0] hi;
  logic [31:0] lo;

  modport master (output start, md_op, a, b, cancel, md_in_d,
                  input  busy, done, stall_md, hi, lo);
  modport slave  (input  start, md_op, a, b, cancel, md_in_d,
                  output busy, done, stall_md, hi, lo);
endinterface

// File: rtl/mdu_ctrl_arith.sv
// mdu_arith: combinational mult/div/accumulate result for the MDU, plus divide-by-zero flag.
// madd/msub results only exist when MDU_MADD_EN is defined.
module mdu_arith
  import mdu_ctrl_pkg::*;
(
  input  logic [3:0]  op_i,
  input  logic [31:0] a_i,
  input  logic [31:0] b_i,
  input  logic [31:0] hi_i,
  input  logic [31:0] lo_i,
  output logic [31:0] pend_hi_d_o,
  output logic [31:0] pend_lo_d_o,
  output logic        div_zero_o
);

  logic [63:0]        prod_s;
  logic [63:0]        prod_u;
  logic [63:0]        res;
  logic [31:0]        divisor;
  logic signed [31:0] q_s;
  logic signed [31:0] r_s;
  logic [31:0]        q_u;
  logic [31:0]        r_u;

  assign prod_s     = $signed({{32{a_i[31]}}, a_i}) * $signed({{32{b_i[31]}}, b_i});
  assign prod_u     = {32'd0, a_i} * {32'd0, b_i};
  assign div_zero_o = is_div_op(op_i) && (b_i == 32'd0);
  // Substitute a harmless divisor so the divide never sees zero; the result is dropped anyway.
  assign divisor    = (b_i == 32'd0) ? 32'd1 : b_i;

  always_comb begin
    q_s = '0;
    r_s = '0;
    if (a_i == 32'h8000_0000 && b_i == 32'hFFFF_FFFF) begin
      q_s = 32'sh8000_0000;
      r_s = '0;
    end else begin
      q_s = $signed(a_i) / $signed(divisor);
      r_s = $signed(a_i) % $signed(divisor);
    end
  end

  assign q_u = a_i / divisor;
  assign r_u = a_i % divisor;

  always_comb begin
    res = {hi_i, lo_i};
    case (op_i)
      MD_MULT:  res = prod_s;
      MD_MULTU: res = prod_u;
      MD_DIV:   res = {r_s, q_s};
      MD_DIVU:  res = {r_u, q_u};
`ifdef MDU_MADD_EN
      MD_MADD:  res = {hi_i, lo_i} + prod_s;
      MD_MADDU: res = {hi_i, lo_i} + prod_u;
      MD_MSUB:  res = {hi_i, lo_i} - prod_s;
      MD_MSUBU: res = {hi_i, lo_i} - prod_u;
`endif
      default:  res = {hi_i, lo_i};
    endcase
  end

  assign pend_hi_d_o = res[63:32];
  assign pend_lo_d_o = res[31:0];

endmodule

// File: rtl/mdu_ctrl.sv
// mdu_ctrl: HI/LO registers and fixed-latency busy sequencer for the E-stage MDU.
// Madd-class ops are accepted only when MDU_MADD_EN is defined; otherwise they are no-ops.
module mdu_ctrl
  import mdu_ctrl_pkg::*;
#(
  parameter int MULT_CYCLES = DEF_MULT_CYCLES,
  parameter int DIV_CYCLES  = DEF_DIV_CYCLES
) (
  input logic        clk,
  input logic        reset,
  mdu_ctrl_if.slave  md
);

  localparam logic [3:0] MULT_LAT = 4'(MULT_CYCLES);
  localparam logic [3:0] DIV_LAT  = 4'(DIV_CYCLES);

  mdu_state_e  state_q;
  logic [3:0]  cnt_q;
  logic [31:0] hi_q, lo_q;
  logic [31:0] pend_hi_q, pend_lo_q;
  logic [31:0] pend_hi_d, pend_lo_d;
  logic        dz_q;
  logic        busy_q, done_q;
  logic        div_zero;
  logic        accept;

  mdu_arith u_arith (
    .op_i        (md.md_op),
    .a_i         (md.a),
    .b_i         (md.b),
    .hi_i        (hi_q),
    .lo_i        (lo_q),
    .pend_hi_d_o (pend_hi_d),
    .pend_lo_d_o (pend_lo_d),
    .div_zero_o  (div_zero)
  );

  assign accept = md.start && !md.cancel && (state_q == S_IDLE);

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q   <= S_IDLE;
      cnt_q     <= '0;
      hi_q      <= '0;
      lo_q      <= '0;
      pend_hi_q <= '0;
      pend_lo_q <= '0;
      dz_q      <= 1'b0;
      busy_q    <= 1'b0;
      done_q    <= 1'b0;
    end else begin
      done_q <= 1'b0;
      case (state_q)
        S_IDLE: begin
          if (accept) begin
            if (md.md_op == MD_MTHI) begin
              hi_q <= md.a;
            end else if (md.md_op == MD_MTLO) begin
              lo_q <= md.a;
            end else if (is_mult_op(md.md_op) || is_div_op(md.md_op)) begin
              pend_hi_q <= pend_hi_d;
              pend_lo_q <= pend_lo_d;
              dz_q      <= div_zero;
              cnt_q     <= is_div_op(md.md_op) ? DIV_LAT : MULT_LAT;
              state_q   <= S_RUN;
              busy_q    <= 1'b1;
            end
          end
        end
        S_RUN: begin
          // cancel is deliberately ignored here: the op already retired past E.
          if (cnt_q == 4'd1) begin
            if (!dz_q) begin
              hi_q <= pend_hi_q;
              lo_q <= pend_lo_q;
            end
            cnt_q   <= '0;
            state_q <= S_IDLE;
            busy_q  <= 1'b0;
            done_q  <= 1'b1;
          end else begin
            cnt_q <= cnt_q - 4'd1;
          end
        end
        default: begin
          state_q <= S_IDLE;
          busy_q  <= 1'b0;
        end
      endcase
    end
  end

  assign md.busy     = busy_q;
  assign md.done     = done_q;
  assign md.hi       = hi_q;
  assign md.lo       = lo_q;
  assign md.stall_md = md.md_in_d && (busy_q || md.start);

endmodule

// File: tb/tb_mdu_ctrl.sv
// Directed self-checking bench for mdu_ctrl: mult/div results, latency, stall, cancel, reset.
module tb_mdu_ctrl;
  import mdu_ctrl_pkg::*;

  logic clk;
  logic reset;
  int   n_chk;
  int   n_pass;

  mdu_ctrl_if md ();

  mdu_ctrl #(.MULT_CYCLES(5), .DIV_CYCLES(10)) dut (
    .clk   (clk),
    .reset (reset),
    .md    (md)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_chk++;
    if (got === exp) n_pass++;
    else $display("FAIL %s: got 0x%08h expected 0x%08h", tag, got, exp);
  endtask

  task automatic next_cyc();
    @(posedge clk);
    #1;
  endtask

  // Drive one E-stage request for a single cycle; returns one step after the accepting edge.
  task automatic issue(input logic [3:0] op, input logic [31:0] a, input logic [31:0] b,
                       input logic cancel_v);
    md.md_op  = op;
    md.a      = a;
    md.b      = b;
    md.cancel = cancel_v;
    md.start  = 1'b1;
    #1;
    chk("stall_start", 32'(md.stall_md), 32'(md.md_in_d));
    next_cyc();
    md.start  = 1'b0;
    md.cancel = 1'b0;
  endtask

  // Full op: checks n busy cycles, then the commit cycle. Ends inside cycle t+N+1.
  task automatic run_op(input string name, input logic [3:0] op, input logic [31:0] a,
                        input logic [31:0] b, input int n, input logic [31:0] exp_hi,
                        input logic [31:0] exp_lo, input logic chk_done);
    issue(op, a, b, 1'b0);
    for (int i = 0; i < n; i++) begin
      chk({name, "_busy"}, 32'(md.busy), 32'd1);
      chk({name, "_stall_busy"}, 32'(md.stall_md), 32'(md.md_in_d));
      chk({name, "_done_early"}, 32'(md.done), 32'd0);
      next_cyc();
    end
    chk({name, "_busy_end"}, 32'(md.busy), 32'd0);
    if (chk_done) chk({name, "_done"}, 32'(md.done), 32'd1);
    chk({name, "_stall_end"}, 32'(md.stall_md), 32'd0);
    chk({name, "_hi"}, md.hi, exp_hi);
    chk({name, "_lo"}, md.lo, exp_lo);
  endtask

  initial begin
    logic seen_done;
    n_chk     = 0;
    n_pass    = 0;
    reset     = 1'b1;
    md.start  = 1'b1;
    md.md_op  = MD_MULT;
    md.a      = '0;
    md.b      = '0;
    md.cancel = 1'b0;
    md.md_in_d = 1'b1;
    #3;
    chk("rst_busy", 32'(md.busy), 32'd0);
    chk("rst_done", 32'(md.done), 32'd0);
    chk("rst_hi", md.hi, 32'd0);
    chk("rst_lo", md.lo, 32'd0);
    chk("rst_stall_start", 32'(md.stall_md), 32'd1);
    md.start = 1'b0;
    #1;
    chk("rst_stall_idle", 32'(md.stall_md), 32'd0);
    next_cyc();
    reset = 1'b0;
    next_cyc();

    run_op("mult", MD_MULT, 32'hFFFF_FFFE, 32'd3, 5, 32'hFFFF_FFFF, 32'hFFFF_FFFA, 1'b1);
    // Back-to-back: next op issued in the commit cycle of the previous one.
    run_op("multu", MD_MULTU, 32'hFFFF_FFFE, 32'd3, 5, 32'h0000_0002, 32'hFFFF_FFFA, 1'b1);
    md.md_in_d = 1'b0;
    run_op("div", MD_DIV, 32'hFFFF_FFF9, 32'd2, 10, 32'hFFFF_FFFF, 32'hFFFF_FFFD, 1'b1);
    run_op("divu_zero", MD_DIVU, 32'd7, 32'd0, 10, 32'hFFFF_FFFF, 32'hFFFF_FFFD, 1'b0);
    run_op("div_ovf", MD_DIV, 32'h8000_0000, 32'hFFFF_FFFF, 10, 32'h0, 32'h8000_0000, 1'b1);
    run_op("divu", MD_DIVU, 32'hFFFF_FFFF, 32'd16, 10, 32'h0000_000F, 32'h0FFF_FFFF, 1'b1);

    issue(MD_MTHI, 32'h1234_5678, 32'd0, 1'b1);
    chk("cancel_hi", md.hi, 32'h0000_000F);
    chk("cancel_busy", 32'(md.busy), 32'd0);
    issue(MD_MTHI, 32'h1234_5678, 32'd0, 1'b0);
    chk("mthi_hi", md.hi, 32'h1234_5678);
    chk("mthi_busy", 32'(md.busy), 32'd0);
    chk("mthi_done", 32'(md.done), 32'd0);
    issue(MD_MTLO, 32'hFFFF_FFFF, 32'd0, 1'b0);
    chk("mtlo_lo", md.lo, 32'hFFFF_FFFF);
    issue(MD_MTHI, 32'h0, 32'd0, 1'b0);
    chk("mthi0_hi", md.hi, 32'h0);

`ifdef MDU_MADD_EN
    run_op("maddu", MD_MADDU, 32'd1, 32'd1, 5, 32'h0000_0001, 32'h0000_0000, 1'b1);
`else
    issue(MD_MADDU, 32'd1, 32'd1, 1'b0);
    chk("maddu_nop_busy", 32'(md.busy), 32'd0);
    repeat (6) next_cyc();
    chk("maddu_nop_hi", md.hi, 32'h0);
    chk("maddu_nop_lo", md.lo, 32'hFFFF_FFFF);
    chk("maddu_nop_done", 32'(md.done), 32'd0);
`endif
    next_cyc();

    // Reset in the 3rd busy cycle of a div.
    issue(MD_DIV, 32'd100, 32'd7, 1'b0);
    next_cyc();
    next_cyc();
    chk("rstmid_busy_before", 32'(md.busy), 32'd1);
    reset = 1'b1;
    #1;
    chk("rstmid_busy", 32'(md.busy), 32'd0);
    chk("rstmid_hi", md.hi, 32'd0);
    chk("rstmid_lo", md.lo, 32'd0);
    next_cyc();
    reset = 1'b0;
    seen_done = 1'b0;
    for (int i = 0; i < 14; i++) begin
      if (md.done) seen_done = 1'b1;
      next_cyc();
    end
    chk("rstmid_no_done", 32'(seen_done), 32'd0);
    chk("rstmid_hi_after", md.hi, 32'd0);

    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL timeout: got no finish expected finish");
    $fatal(1);
  end

endmodule
